// File: rtl/enc_hamming_secded.sv
// Hamming SEC encoder behind a 2-stage valid/ready pipeline with optional single-bit error injection.
// Define ENC_OVERALL_PARITY_EN to add the overall parity bit at code_out[0] (SECDED).
module enc_hamming_secded #(
  parameter int DATA_W = 4,
  localparam int PAR_W = (DATA_W <= 4)  ? 3 :
                         (DATA_W <= 11) ? 4 :
                         (DATA_W <= 26) ? 5 :
                         (DATA_W <= 57) ? 6 : 7,
`ifdef ENC_OVERALL_PARITY_EN
  localparam int CW_W = DATA_W + PAR_W + 1
`else
  localparam int CW_W = DATA_W + PAR_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              inj_en,
  input  logic [7:0]        inj_pos,
  output logic [CW_W-1:0]   code_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              inj_flag,
  output logic [15:0]       word_cnt
);

  localparam int HAM_N = DATA_W + PAR_W;

  logic              s1Valid;
  logic [DATA_W-1:0] s1Data;
  logic              s1Inj;
  logic [7:0]        s1Pos;
  logic              s2Advance;
  logic              injHit;

  // Hamming position p lives at bit p-1 of h; the optional overall bit is prepended below it.
  function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d,
                                             input logic inj,
                                             input logic [7:0] pos);
    logic [HAM_N-1:0]  h;
    logic [HAM_N-1:0]  sh;
    logic [DATA_W-1:0] rest;
    logic [CW_W-1:0]   cw;
    logic              par;
    h    = '0;
    rest = d;
    for (int p = 1; p <= HAM_N; p++) begin
      if ((p & (p - 1)) != 0) begin
        h    = h | (HAM_N'(rest[0]) << (p - 1));
        rest = rest >> 1;
      end
    end
    for (int i = 0; i < PAR_W; i++) begin
      par = 1'b0;
      for (int p = 1; p <= HAM_N; p++) begin
        sh = h >> (p - 1);
        if (((p >> i) & 1) != 0) par = par ^ sh[0];
      end
      h = h | (HAM_N'(par) << ((1 << i) - 1));
    end
`ifdef ENC_OVERALL_PARITY_EN
    cw = {h, ^h};
`else
    cw = h;
`endif
    if (inj && (int'(pos) < CW_W)) cw = cw ^ (CW_W'(1) << pos);
    return cw;
  endfunction

  assign s2Advance = !out_valid || out_ready;
  assign in_ready  = !rst && (!s1Valid || s2Advance);
  assign injHit    = s1Inj && (int'(s1Pos) < CW_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid <= 1'b0;
      s1Data  <= '0;
      s1Inj   <= 1'b0;
      s1Pos   <= '0;
    end else if (in_ready) begin
      s1Valid <= in_valid;
      s1Data  <= data_in;
      s1Inj   <= in_valid && inj_en;
      s1Pos   <= inj_pos;
    end
  end

  // Output stage only reloads when it is empty or being drained, so a stalled word stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      code_out  <= '0;
      inj_flag  <= 1'b0;
    end else if (s2Advance) begin
      out_valid <= s1Valid;
      if (s1Valid) begin
        code_out <= encode(s1Data, s1Inj, s1Pos);
        inj_flag <= injHit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (out_valid && out_ready) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_enc_hamming_secded.sv
// Bench for enc_hamming_secded: 4-bit directed vectors and stream/reset sequences,
// plus a 64-bit instance checked by syndrome decoding; follows ENC_OVERALL_PARITY_EN.
module tb_enc_hamming_secded;

`ifdef ENC_OVERALL_PARITY_EN
  localparam int CW4  = 8;
  localparam int CW64 = 72;
`else
  localparam int CW4  = 7;
  localparam int CW64 = 71;
`endif

  typedef struct {
    logic [3:0] data;
    logic       inj;
    logic [7:0] pos;
    logic [7:0] code;
    logic       flag;
  } vec_t;

  logic clk;
  logic rst4, rst64;

  logic [3:0]     data4;
  logic           inValid4, inReady4, injEn4, outValid4, outReady4, injFlag4;
  logic [7:0]     injPos4;
  logic [CW4-1:0] code4;
  logic [15:0]    wordCnt4;

  logic [63:0]     data64;
  logic            inValid64, inReady64, injEn64, outValid64, outReady64, injFlag64;
  logic [7:0]      injPos64;
  logic [CW64-1:0] code64;
  logic [15:0]     wordCnt64;

  int checks = 0;
  int errors = 0;

  vec_t       vecs[13];
  logic [7:0] expSec4[16];

  enc_hamming_secded #(.DATA_W(4)) dut4 (
    .clk(clk), .rst(rst4), .data_in(data4), .in_valid(inValid4), .in_ready(inReady4),
    .inj_en(injEn4), .inj_pos(injPos4), .code_out(code4), .out_valid(outValid4),
    .out_ready(outReady4), .inj_flag(injFlag4), .word_cnt(wordCnt4)
  );

  enc_hamming_secded #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst64), .data_in(data64), .in_valid(inValid64), .in_ready(inReady64),
    .inj_en(injEn64), .inj_pos(injPos64), .code_out(code64), .out_valid(outValid64),
    .out_ready(outReady64), .inj_flag(injFlag64), .word_cnt(wordCnt64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] d, input logic inj, input logic [7:0] pos);
    data4    = d;
    injEn4   = inj;
    injPos4  = pos;
    inValid4 = 1'b1;
  endtask

  // Decode a 64-bit-data codeword: syndrome must be zero, recovered data must match, overall parity even.
  task automatic checkCw64(input logic [CW64-1:0] cw, input logic [63:0] d);
    int              syn;
    int              k;
    logic [63:0]     dOut;
    logic [CW64-1:0] t;
    logic            b;
    syn  = 0;
    k    = 0;
    dOut = '0;
    for (int p = 1; p <= 71; p++) begin
`ifdef ENC_OVERALL_PARITY_EN
      t = cw >> p;
`else
      t = cw >> (p - 1);
`endif
      b = t[0];
      if (b) syn = syn ^ p;
      if ((p & (p - 1)) != 0) begin
        dOut = dOut | (64'(b) << k);
        k++;
      end
    end
    checkOutput("cw64_syndrome", syn, 0);
    checkOutput("cw64_data", dOut, d);
`ifdef ENC_OVERALL_PARITY_EN
    checkOutput("cw64_parity", ^cw, 0);
`endif
  endtask

  task automatic run64(input int nWords, input int budget, input bit rnd);
    logic [63:0] q[$];
    logic [63:0] d;
    int          sent;
    int          recv;
    sent = 0;
    recv = 0;
    for (int c = 0; c < budget && recv < nWords; c++) begin
      @(negedge clk);
      outReady64 = rnd ? ($urandom_range(3) != 0) : 1'b1;
      inValid64  = (sent < nWords) && (rnd ? ($urandom_range(3) != 0) : 1'b1);
      data64     = {$urandom, $urandom};
      #1;
      if (outValid64 && outReady64) begin
        if (q.size() == 0) begin
          checkOutput("cw64_spurious", 1, 0);
        end else begin
          d = q.pop_front();
          checkCw64(code64, d);
        end
        recv++;
      end
      if (inValid64 && inReady64) begin
        q.push_back(data64);
        sent++;
      end
    end
    checkOutput("cw64_count", recv, nWords);
    @(negedge clk);
    inValid64 = 1'b0;
  endtask

  task automatic runStream4();
    int             sent;
    int             recv;
    int             occ;
    int             lowSeen;
    bit             acc;
    bit             emit;
    bit             prevHeld;
    logic [CW4-1:0] heldCode;
    sent     = 0;
    recv     = 0;
    occ      = 0;
    lowSeen  = 0;
    prevHeld = 1'b0;
    heldCode = '0;
    for (int c = 0; c < 100 && recv < 20; c++) begin
      @(negedge clk);
      outReady4 = !(c >= 5 && c <= 8);
      injEn4    = 1'b0;
      inValid4  = (sent < 20);
      data4     = 4'(sent);
      #1;
      checkOutput("stream_in_ready", inReady4, (occ == 2) ? outReady4 : 1'b1);
      if (!inReady4) lowSeen++;
      if (prevHeld) begin
        checkOutput("hold_valid", outValid4, 1);
        checkOutput("hold_code", code4, heldCode);
      end
      prevHeld = outValid4 && !outReady4;
      heldCode = code4;
      emit = outValid4 && outReady4;
      if (emit) begin
        checkOutput("stream_code", code4, expSec4[recv % 16]);
        recv++;
      end
      acc = inValid4 && inReady4;
      if (acc) sent++;
      occ = occ + int'(acc) - int'(emit);
    end
    checkOutput("stream_count", recv, 20);
    checkOutput("stream_in_ready_low_seen", lowSeen != 0, 1);
    @(negedge clk);
    inValid4 = 1'b0;
    checkOutput("stream_word_cnt", wordCnt4, 20);
  endtask

  initial begin
`ifdef ENC_OVERALL_PARITY_EN
    expSec4 = '{8'h00, 8'h0F, 8'h33, 8'h3C, 8'h55, 8'h5A, 8'h66, 8'h69,
                8'h96, 8'h99, 8'hA5, 8'hAA, 8'hC3, 8'hCC, 8'hF0, 8'hFF};
    vecs[0]  = '{4'hB, 1'b0, 8'd0,   8'hAA, 1'b0};
    vecs[1]  = '{4'hF, 1'b0, 8'd0,   8'hFF, 1'b0};
    vecs[2]  = '{4'h0, 1'b0, 8'd0,   8'h00, 1'b0};
    vecs[3]  = '{4'h1, 1'b0, 8'd0,   8'h0F, 1'b0};
    vecs[4]  = '{4'h2, 1'b0, 8'd0,   8'h33, 1'b0};
    vecs[5]  = '{4'h4, 1'b0, 8'd0,   8'h55, 1'b0};
    vecs[6]  = '{4'h8, 1'b0, 8'd0,   8'h96, 1'b0};
    vecs[7]  = '{4'hB, 1'b1, 8'd3,   8'hA2, 1'b1};
    vecs[8]  = '{4'hB, 1'b1, 8'd8,   8'hAA, 1'b0};
    vecs[9]  = '{4'hB, 1'b1, 8'd7,   8'h2A, 1'b1};
    vecs[10] = '{4'hB, 1'b1, 8'd0,   8'hAB, 1'b1};
    vecs[11] = '{4'h0, 1'b1, 8'd255, 8'h00, 1'b0};
    vecs[12] = '{4'h0, 1'b0, 8'd2,   8'h00, 1'b0};
`else
    expSec4 = '{8'h00, 8'h07, 8'h19, 8'h1E, 8'h2A, 8'h2D, 8'h33, 8'h34,
                8'h4B, 8'h4C, 8'h52, 8'h55, 8'h61, 8'h66, 8'h78, 8'h7F};
    vecs[0]  = '{4'hB, 1'b0, 8'd0,   8'h55, 1'b0};
    vecs[1]  = '{4'hF, 1'b0, 8'd0,   8'h7F, 1'b0};
    vecs[2]  = '{4'h0, 1'b0, 8'd0,   8'h00, 1'b0};
    vecs[3]  = '{4'h1, 1'b0, 8'd0,   8'h07, 1'b0};
    vecs[4]  = '{4'h2, 1'b0, 8'd0,   8'h19, 1'b0};
    vecs[5]  = '{4'h4, 1'b0, 8'd0,   8'h2A, 1'b0};
    vecs[6]  = '{4'h8, 1'b0, 8'd0,   8'h4B, 1'b0};
    vecs[7]  = '{4'hB, 1'b1, 8'd3,   8'h5D, 1'b1};
    vecs[8]  = '{4'hB, 1'b1, 8'd8,   8'h55, 1'b0};
    vecs[9]  = '{4'hB, 1'b1, 8'd7,   8'h55, 1'b0};
    vecs[10] = '{4'hB, 1'b1, 8'd0,   8'h54, 1'b1};
    vecs[11] = '{4'h0, 1'b1, 8'd255, 8'h00, 1'b0};
    vecs[12] = '{4'h0, 1'b0, 8'd2,   8'h00, 1'b0};
`endif

    rst4 = 1'b1; rst64 = 1'b1;
    data4 = '0; inValid4 = 1'b0; injEn4 = 1'b0; injPos4 = '0; outReady4 = 1'b1;
    data64 = '0; inValid64 = 1'b0; injEn64 = 1'b0; injPos64 = '0; outReady64 = 1'b1;

    // Reset state, with in_ready held low while reset is asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", outValid4, 0);
    checkOutput("rst_code_out", code4, 0);
    checkOutput("rst_inj_flag", injFlag4, 0);
    checkOutput("rst_word_cnt", wordCnt4, 0);
    checkOutput("rst_in_ready", inReady4, 0);
    rst4 = 1'b0; rst64 = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", inReady4, 1);

    // Single words: out_valid low one cycle after acceptance, high with the codeword two cycles after.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].data, vecs[i].inj, vecs[i].pos);
      outReady4 = 1'b1;
      #1;
      checkOutput("vec_in_ready", inReady4, 1);
      @(negedge clk);
      inValid4 = 1'b0;
      checkOutput("vec_latency_early", outValid4, 0);
      @(negedge clk);
      checkOutput("vec_out_valid", outValid4, 1);
      checkOutput("vec_code_out", code4, vecs[i].code);
      checkOutput("vec_inj_flag", injFlag4, vecs[i].flag);
    end
    @(negedge clk);
    checkOutput("vec_word_cnt", wordCnt4, 13);

    // Back-to-back stream with a 4-cycle downstream stall.
    @(negedge clk); rst4 = 1'b1;
    @(negedge clk); rst4 = 1'b0;
    runStream4();

    // Reset with two words in flight.
    @(negedge clk);
    outReady4 = 1'b0;
    applyStimulus(4'h3, 1'b0, 8'd0);
    @(negedge clk);
    applyStimulus(4'h5, 1'b0, 8'd0);
    #1;
    checkOutput("flight_in_ready", inReady4, 1);
    @(negedge clk);
    inValid4 = 1'b0;
    checkOutput("flight_full_valid", outValid4, 1);
    rst4 = 1'b1;
    #1;
    checkOutput("flight_rst_in_ready", inReady4, 0);
    @(negedge clk);
    rst4 = 1'b0;
    outReady4 = 1'b1;
    checkOutput("flight_rst_out_valid", outValid4, 0);
    checkOutput("flight_rst_word_cnt", wordCnt4, 0);
    checkOutput("flight_rst_code_out", code4, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("flight_no_stale", outValid4, 0);
    end

    // 64-bit data: random flow control, then a long stream that wraps word_cnt.
    run64(300, 3000, 1'b1);
    checkOutput("w64_word_cnt", wordCnt64, 300);
    @(negedge clk); rst64 = 1'b1;
    @(negedge clk); rst64 = 1'b0;
    run64(65536, 70000, 1'b0);
    checkOutput("w64_word_cnt_wrap", wordCnt64, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enc_hamming_secded.md
ENC_HAMMING_SECDED -- requirements
Module: enc_hamming_secded

Interface
REQ-001 SHALL have parameter DATA_W, default 4, meaning data word width in bits; legal range 4..64.
REQ-002 SHALL derive localparam PAR_W as the smallest r with 2^r >= DATA_W+r+1, which is 3 for DATA_W=4 and 7 for DATA_W=64.
REQ-003 SHALL derive localparam CW_W as DATA_W+PAR_W+1 with ENC_OVERALL_PARITY_EN, else DATA_W+PAR_W.
REQ-004 SHALL have one clock and a synchronous, active-high reset, as follows:
  clk        input   1         single clock; all state on rising edge
  rst        input   1         synchronous, active-high reset
  data_in    input   DATA_W    data word to encode
  in_valid   input   1         data_in valid
  in_ready   output  1         encoder accepts a word this cycle
  inj_en     input   1         flip one codeword bit for this word
  inj_pos    input   8         codeword bit index to flip
  code_out   output  CW_W      encoded codeword
  out_valid  output  1         code_out valid
  out_ready  input   1         downstream accepts code_out
  inj_flag   output  1         current code_out carries an injected flip
  word_cnt   output  16        count of completed output handshakes

Function
REQ-005 SHALL place Hamming positions 1..DATA_W+PAR_W with parity at power-of-two positions and data bits in ascending order at the remaining positions (position 3 holds data_in[0]).
REQ-006 SHALL compute parity bit at position 2^i as the XOR of all positions whose index has bit i set, excluding the parity position itself.
REQ-007 SHALL map position p to code_out[p] with ENC_OVERALL_PARITY_EN, and to code_out[p-1] without it.
REQ-008 SHALL use a 2-stage pipeline: stage 1 registers data_in, inj_en and inj_pos; stage 2 registers the codeword.
REQ-009 SHALL accept a word when in_valid && in_ready, and SHALL complete an output transfer when out_valid && out_ready.
REQ-010 SHALL present the codeword with out_valid high exactly 2 cycles after acceptance when out_ready is held high.
REQ-011 SHALL sustain 1 word/cycle throughput under continuous in_valid and out_ready.
REQ-012 SHALL advance each stage when it is empty or when its downstream stage advances in the same cycle.
REQ-013 SHALL drive in_ready as !stage1_valid || stage1_advance, combinationally, with no combinational path from in_valid to in_ready.
REQ-014 SHALL hold code_out, inj_flag and out_valid stable while out_valid && !out_ready.
REQ-015 SHALL, when inj_en was high at acceptance and inj_pos < CW_W, invert code_out[inj_pos] after all parity is computed and set inj_flag=1.
REQ-016 SHALL, when inj_pos >= CW_W, apply no flip and set inj_flag=0.
REQ-017 SHALL increment word_cnt on every output handshake and wrap from 16'hFFFF to 16'h0000.
REQ-018 SHALL never drop, duplicate or reorder words under any in_valid/out_ready pattern.
REQ-019 SHALL treat acceptance and output handshake in the same cycle as normal flow-through, leaving occupancy unchanged.

Reset
REQ-020 SHALL, when rst is high at a clock edge, clear both stage valids, out_valid, inj_flag, code_out and word_cnt to 0.
REQ-021 SHALL drive in_ready=0 during any cycle in which rst is high.
REQ-022 SHALL discard in-flight words when rst asserts mid-stream, with no partial output afterwards.

Configuration
REQ-023 SHALL, with ENC_OVERALL_PARITY_EN defined, set code_out[0] to the XOR of all Hamming positions, computed before injection, giving SECDED.
REQ-024 SHALL, without ENC_OVERALL_PARITY_EN, omit the overall parity bit and produce a plain SEC codeword; all other behaviour is unchanged.

Verification
REQ-025 SHALL cover: DATA_W=4, macro off, data_in=4'b1011 -> code_out=7'h55, 2 cycles after acceptance.
REQ-026 SHALL cover: DATA_W=4, macro on, data_in=4'b1011 -> 8'hAA; data_in=4'hF -> 8'hFF; data_in=4'h0 -> 8'h00.
REQ-027 SHALL cover: 20 words back-to-back with out_ready low on cycles 5-8 -> in_ready low while both stages are full, outputs in order with none lost, word_cnt=20.
REQ-028 SHALL cover: macro on, data_in=4'b1011, inj_en=1, inj_pos=3 -> code_out=8'hA2, inj_flag=1; same word with inj_pos=8 -> 8'hAA, inj_flag=0.
REQ-029 SHALL cover: rst asserted for 1 cycle with 2 words in flight -> next cycle out_valid=0, word_cnt=0, no stale codeword emitted.
REQ-030 SHALL cover: DATA_W=64 random stimulus against a reference model -> CW_W=72 with macro on, every codeword matches, 65536+ handshakes wrap word_cnt to 0.
